// File: rtl/gb_oam_dma.sv
// OAM DMA engine: a write to $FF46 copies OAM_BYTES bytes from page XX (echo pages remapped)
// into OAM, pacing one byte start every CYCLES_PER_BYTE cycles when the targets respond at once.
//
//   state | meaning
//   IDLE  | no transfer; waiting for a $FF46 write
//   DELAY | start-up delay before the first source read
//   READ  | source read request held until Ready and DataReady
//   WRITE | OAM write request held until OamReady
//   PACE  | wait for the byte period (measured from READ entry) to expire
module gb_oam_dma #(
  parameter int OAM_BYTES       = 160,
  parameter int START_DELAY     = 4,
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RegWrite,
  input  logic [7:0]  RegData,
  output logic [7:0]  RegValue,
  output logic        Busy,
  output logic        SrcAccess,
  output logic [15:0] SrcAddress,
  input  logic [7:0]  SrcDToInitiator,
  input  logic        SrcReady,
  input  logic        SrcDataReady,
  output logic        OamAccess,
  output logic        OamWrite,
  output logic [7:0]  OamAddress,
  output logic [7:0]  OamDToTarget,
  input  logic        OamReady
);

  localparam logic [7:0] LAST_IDX   = 8'(OAM_BYTES - 1);
  localparam logic [7:0] DELAY_LOAD = 8'(START_DELAY - 1);
  localparam logic [7:0] PACE_LOAD  = 8'(CYCLES_PER_BYTE - 1);

  typedef enum logic [2:0] {IDLE, DELAY, READ, WRITE, PACE} state_t;

  state_t      state, stateNext;
  logic [7:0]  byteIdx;
  logic [7:0]  delayCnt;
  logic [7:0]  paceCnt;
  logic [7:0]  srcBase;
  logic [7:0]  dataLatch;
  logic [7:0]  regValue;
  logic        restartPend;

  logic        startDelay;
  logic        enterRead;
  logic        incIdx;
  logic        latchData;

  // Pages $E0-$FF are the echo of WRAM $C0-$DF.
  function automatic logic [7:0] srcPage(input logic [7:0] d);
    return (d >= 8'hE0) ? d - 8'h20 : d;
  endfunction

  always_comb begin
    stateNext  = state;
    startDelay = 1'b0;
    enterRead  = 1'b0;
    incIdx     = 1'b0;
    latchData  = 1'b0;
    case (state)
      IDLE: begin
        if (RegWrite) begin
          stateNext  = DELAY;
          startDelay = 1'b1;
        end
      end
      DELAY: begin
        if (RegWrite) begin
          startDelay = 1'b1;
        end else if (delayCnt == 8'd0) begin
          stateNext = READ;
          enterRead = 1'b1;
        end
      end
      READ: begin
        if (SrcReady && SrcDataReady) begin
          latchData = 1'b1;
          if (restartPend || RegWrite) begin
            stateNext  = DELAY;
            startDelay = 1'b1;
          end else begin
            stateNext = WRITE;
          end
        end
      end
      WRITE: begin
        if (OamReady) begin
          if (restartPend || RegWrite) begin
            stateNext  = DELAY;
            startDelay = 1'b1;
          end else if (byteIdx == LAST_IDX) begin
            stateNext = IDLE;
          end else begin
            stateNext = PACE;
            incIdx    = 1'b1;
          end
        end
      end
      PACE: begin
        if (RegWrite) begin
          stateNext  = DELAY;
          startDelay = 1'b1;
        end else if (paceCnt == 8'd0) begin
          stateNext = READ;
          enterRead = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      byteIdx     <= 8'd0;
      delayCnt    <= 8'd0;
      paceCnt     <= 8'd0;
      srcBase     <= 8'd0;
      dataLatch   <= 8'd0;
      regValue    <= 8'd0;
      restartPend <= 1'b0;
    end else begin
      state <= stateNext;
      if (RegWrite) regValue <= RegData;
      // A restart resolved from a pending flag picks up the most recent $FF46 value.
      if (startDelay) begin
        byteIdx  <= 8'd0;
        delayCnt <= DELAY_LOAD;
        srcBase  <= srcPage(RegWrite ? RegData : regValue);
      end else begin
        if (incIdx) byteIdx <= byteIdx + 8'd1;
        if (delayCnt != 8'd0) delayCnt <= delayCnt - 8'd1;
      end
      if (startDelay) restartPend <= 1'b0;
      else if (RegWrite && (state == READ || state == WRITE)) restartPend <= 1'b1;
      if (enterRead) paceCnt <= PACE_LOAD;
      else if (paceCnt != 8'd0) paceCnt <= paceCnt - 8'd1;
      if (latchData) dataLatch <= SrcDToInitiator;
    end
  end

  assign RegValue     = regValue;
  assign Busy         = (state != IDLE);
  assign SrcAccess    = (state == READ);
  assign SrcAddress   = SrcAccess ? {srcBase, byteIdx} : 16'h0000;
  assign OamAccess    = (state == WRITE);
  assign OamWrite     = OamAccess;
  assign OamAddress   = OamAccess ? byteIdx : 8'h00;
  assign OamDToTarget = OamAccess ? dataLatch : 8'h00;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: random source memory and target stalls, checked against a byte-level
// transfer model (expected address, data, timing of each byte and Busy every cycle).
module tb_gb_oam_dma;
  localparam int OAM_BYTES   = 160;
  localparam int START_DELAY = 4;
  localparam int CPB         = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWrite;
  logic [7:0]  RegData;
  logic [7:0]  RegValue;
  logic        Busy;
  logic        SrcAccess;
  logic [15:0] SrcAddress;
  logic [7:0]  SrcDToInitiator;
  logic        SrcReady;
  logic        SrcDataReady;
  logic        OamAccess;
  logic        OamWrite;
  logic [7:0]  OamAddress;
  logic [7:0]  OamDToTarget;
  logic        OamReady;

  gb_oam_dma #(.OAM_BYTES(OAM_BYTES), .START_DELAY(START_DELAY), .CYCLES_PER_BYTE(CPB)) dut (
    .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .RegData(RegData), .RegValue(RegValue),
    .Busy(Busy), .SrcAccess(SrcAccess), .SrcAddress(SrcAddress),
    .SrcDToInitiator(SrcDToInitiator), .SrcReady(SrcReady), .SrcDataReady(SrcDataReady),
    .OamAccess(OamAccess), .OamWrite(OamWrite), .OamAddress(OamAddress),
    .OamDToTarget(OamDToTarget), .OamReady(OamReady)
  );

  initial forever #5 CLK = ~CLK;

  logic [7:0] mem [0:65535];
  int nTests = 0, nFail = 0, cyc = 0;

  // reference model of the transfer
  bit         mActive, mPend, mBusy;
  logic [7:0] mBase, mPendBase, mRegValue;
  int         mIdx, nextReadExp, readStartCyc, writesDone, busyCount;
  // bench-side handshake tracking and stimulus knobs
  bit         inRead, inWrite, cmdValid, rstFired;
  logic [7:0] cmdData, restartData, heldOamAddr, heldOamData;
  logic [15:0] heldSrc;
  int         readWait, oamWait, srcStallIdx, srcStallCycles, oamDelay, restartIdx, rstIdx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] remap(input logic [7:0] d);
    return (d >= 8'hE0) ? d - 8'h20 : d;
  endfunction

  function automatic int srcExp();
    return int'(mBase) * 256 + mIdx;
  endfunction

  function automatic logic [7:0] randPage();
    return 8'($urandom_range(8'hC0, 8'hDF));
  endfunction

  task automatic clearModel();
    mActive = 0; mPend = 0; mBusy = 0; mRegValue = 8'h00; mIdx = 0; nextReadExp = -1;
    inRead = 0; inWrite = 0;
  endtask

  task automatic restart();
    mBase = mPendBase; mIdx = 0; mPend = 0; nextReadExp = cyc + 1 + START_DELAY;
  endtask

  // One clock: observe outputs away from the edge, then drive the inputs for the next edge.
  task automatic tick();
    bit stall;
    @(negedge CLK);
    cyc++;
    RegWrite = 1'b0;
    check("busy", Busy, mBusy);
    check("regValue", RegValue, mRegValue);
    if (Busy) busyCount++;
    if (cmdValid) begin
      cmdValid = 0; RegWrite = 1'b1; RegData = cmdData; mRegValue = cmdData; mBusy = 1;
      mActive = 1; mBase = remap(cmdData); mIdx = 0; nextReadExp = cyc + 1 + START_DELAY;
    end
    SrcReady = 1'b0; SrcDataReady = 1'b0; SrcDToInitiator = 8'($urandom);
    if (SrcAccess) begin
      if (!inRead) begin
        inRead = 1; readWait = 0; readStartCyc = cyc; heldSrc = SrcAddress;
        check("srcAddr", SrcAddress, srcExp());
        check("readStart", cyc, nextReadExp);
      end else begin
        readWait++;
        check("srcHold", SrcAddress, heldSrc);
      end
      stall = (mIdx == srcStallIdx) && (readWait < srcStallCycles);
      if (!stall) begin
        SrcReady = 1'b1; SrcDataReady = 1'b1;
      end else if ($urandom_range(0, 1) == 1) begin
        SrcDataReady = 1'($urandom_range(0, 1));
      end else begin
        SrcReady = 1'($urandom_range(0, 1));
      end
      SrcDToInitiator = mem[SrcAddress];
      if (!stall) begin
        inRead = 0;
        if (mPend) restart();
      end
    end
    OamReady = 1'b0;
    if (OamAccess) begin
      if (!inWrite) begin
        inWrite = 1; oamWait = 0; heldOamAddr = OamAddress; heldOamData = OamDToTarget;
        check("oamAddr", OamAddress, mIdx);
        check("oamData", OamDToTarget, mem[srcExp()]);
        if (mIdx == rstIdx) begin
          RST = 1'b1; rstFired = 1; rstIdx = -1;
          clearModel();
          return;
        end
        if (mIdx == restartIdx) begin
          restartIdx = -1; RegWrite = 1'b1; RegData = restartData; mRegValue = restartData;
          mPend = 1; mPendBase = remap(restartData);
        end
      end else begin
        oamWait++;
        check("oamAddrHold", OamAddress, heldOamAddr);
        check("oamDataHold", OamDToTarget, heldOamData);
      end
      check("oamWrite", OamWrite, 1'b1);
      if (oamWait >= oamDelay) begin
        OamReady = 1'b1; inWrite = 0; writesDone++;
        if (mPend) restart();
        else if (mIdx == OAM_BYTES - 1) begin
          mActive = 0; mBusy = 0; nextReadExp = -1;
        end else begin
          mIdx++;
          nextReadExp = (readStartCyc + CPB > cyc + 2) ? readStartCyc + CPB : cyc + 2;
        end
      end
    end
  endtask

  task automatic runTransfer(input logic [7:0] page, input int expWrites);
    int n;
    writesDone = 0; busyCount = 0; cmdData = page; cmdValid = 1;
    tick();
    n = 0;
    while ((mActive || mPend) && n < 6000) begin
      tick();
      n++;
    end
    if (mActive) begin
      check("finished", mActive, 1'b0);
      RST = 1'b1; clearModel(); tick(); RST = 1'b0;
    end
    check("writes", writesDone, expWrites);
    repeat (3) tick();
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "Busy"}, Busy, 1'b0);
    check({tag, "SrcAccess"}, SrcAccess, 1'b0);
    check({tag, "SrcAddress"}, SrcAddress, 16'h0000);
    check({tag, "OamAccess"}, OamAccess, 1'b0);
    check({tag, "OamWrite"}, OamWrite, 1'b0);
    check({tag, "OamAddress"}, OamAddress, 8'h00);
    check({tag, "OamData"}, OamDToTarget, 8'h00);
    check({tag, "RegValue"}, RegValue, 8'h00);
  endtask

  initial begin
    RST = 1'b1; RegWrite = 1'b0; RegData = 8'h00; SrcDToInitiator = 8'h00;
    SrcReady = 1'b0; SrcDataReady = 1'b0; OamReady = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    clearModel();
    cmdValid = 0; rstFired = 0; srcStallIdx = -1; srcStallCycles = 0; oamDelay = 0;
    restartIdx = -1; rstIdx = -1;
    repeat (3) @(negedge CLK);
    checkIdle("reset");
    RST = 1'b0;
    tick();

    // zero-wait transfer, exact Busy length
    runTransfer(8'hC1, OAM_BYTES);
    check("busyLen", busyCount, START_DELAY + (OAM_BYTES - 1) * CPB + 2);
    check("regValC1", RegValue, 8'hC1);

    // echo pages
    runTransfer(8'hE3, OAM_BYTES);
    runTransfer(8'($urandom_range(8'hE0, 8'hFF)), OAM_BYTES);

    // source stall on byte 10
    srcStallIdx = 10; srcStallCycles = 7;
    runTransfer(randPage(), OAM_BYTES);
    srcStallIdx = -1;

    // restart during the write of index 49
    restartIdx = 49; restartData = 8'hD0;
    runTransfer(8'hC0, 50 + OAM_BYTES);

    // reset in the middle of the transfer
    rstIdx = 80; rstFired = 0;
    runTransfer(randPage(), 80);
    check("rstFired", rstFired, 1'b1);
    checkIdle("midRst");
    RST = 1'b0;
    tick();
    runTransfer(randPage(), OAM_BYTES);

    // slow OAM target
    oamDelay = 3;
    runTransfer(randPage(), OAM_BYTES);
    oamDelay = 0;

    // restart coinciding with the final OamReady
    restartIdx = OAM_BYTES - 1; restartData = randPage();
    runTransfer(randPage(), 2 * OAM_BYTES);

    // randomized pages and stalls
    for (int t = 0; t < 3; t++) begin
      srcStallIdx = $urandom_range(0, OAM_BYTES - 1);
      srcStallCycles = $urandom_range(0, 9);
      oamDelay = $urandom_range(0, 2);
      runTransfer(8'($urandom), OAM_BYTES);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
